intr_ctrl: RTL and testbench

Memory-mapped interrupt controller between the I/O devices (switch, key, timer, etc.) and the CPU. It collects the devices' level-sensitive intr lines, masks them, and arbitrates among them with fixed or rotating priority. It presents a single irq to the CPU and sequences the acknowledge/end-of-interrupt handshake over the shared abus/dbus. It does not support nesting: only one interrupt is in service at a time.

---
 rtl/intr_ctrl.sv | 86 ++++++++
 tb/tb_intr_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: masked fixed/rotating-priority interrupt controller; clk, init_n (async low reset), abus/dbus/we CPU bus, dev_intr requests, irq to CPU, cur_id in service
module intr_ctrl #(
  parameter int DBITS = 32,
  parameter int NDEV = 4,
  parameter int ROTATE = 0,
  parameter logic [DBITS-1:0] IMASK_ADDR = 32'hF0000800,
  parameter logic [DBITS-1:0] IID_ADDR = 32'hF0000804,
  parameter logic [DBITS-1:0] IEOI_ADDR = 32'hF0000808,
  parameter logic [DBITS-1:0] ISTAT_ADDR = 32'hF000080C
) (
  input logic clk,
  input logic init_n,
  input logic [DBITS-1:0] abus,
  inout wire [DBITS-1:0] dbus,
  input logic we,
  input logic [NDEV-1:0] dev_intr,
  output logic irq,
  output logic [7:0] cur_id
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t r_state, w_next;
  logic [NDEV-1:0] r_imask, r_pend;
  logic [2:0] r_ptr;
  logic [7:0] r_cur_id, w_winner;
  logic r_err, r_irq;
  logic [DBITS-1:0] w_rdata, w_stat;
  logic w_sel_mask, w_sel_iid, w_sel_eoi, w_sel_stat, w_drive, w_ack, w_eoi_ok, w_eoi_bad, w_unused;
  int w_rank, w_best;
  assign w_sel_mask = abus == IMASK_ADDR;
  assign w_sel_iid = abus == IID_ADDR;
  assign w_sel_eoi = abus == IEOI_ADDR;
  assign w_sel_stat = abus == ISTAT_ADDR;
  assign w_ack = w_sel_iid && !we && r_state == REQ;
  assign w_eoi_ok = w_sel_eoi && we && r_state == SERVICE && dbus[7:0] == r_cur_id;
  assign w_eoi_bad = w_sel_eoi && we && r_state == SERVICE && dbus[7:0] != r_cur_id;
  assign w_unused = ^dbus;
  assign irq = r_irq;
  assign cur_id = r_cur_id;
  // rank each pending source by its distance above the priority pointer; smallest rank wins
  always_comb begin
    w_winner = '0;
    w_best = NDEV;
    w_rank = 0;
    for (int i = 0; i < NDEV; i++) begin
      w_rank = (i - int'(r_ptr) + NDEV) % NDEV;
      if (r_pend[i] && w_rank < w_best) begin
        w_best = w_rank;
        w_winner = 8'(i);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && |r_pend) w_next = REQ;
    if (r_state == REQ) w_next = ~|r_pend ? IDLE : w_ack ? SERVICE : REQ;
    if (r_state == SERVICE && w_eoi_ok) w_next = IDLE;
  end
  assign w_stat = DBITS'({r_irq, r_err, r_state == SERVICE, 16'(r_pend)});
  assign w_rdata = w_sel_mask ? DBITS'(r_imask) :
                   w_sel_iid ? (r_state == REQ ? {1'b1, {(DBITS-9){1'b0}}, w_winner} : '0) :
                   w_sel_stat ? w_stat : '0;
  assign w_drive = init_n && !we && (w_sel_mask || w_sel_iid || w_sel_stat);
  assign dbus = w_drive ? w_rdata : 'z;
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      r_state <= IDLE;
      r_imask <= '0;
      r_pend <= '0;
      r_ptr <= '0;
      r_cur_id <= '0;
      r_err <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend <= dev_intr & r_imask;
      r_irq <= w_next == REQ;
      if (w_sel_mask && we) r_imask <= dbus[NDEV-1:0];
      if (r_state == REQ && w_next == SERVICE) r_cur_id <= w_winner;
      if (w_eoi_ok) begin
        r_cur_id <= '0;
        if (ROTATE != 0) r_ptr <= 3'((int'(r_cur_id) + 1) % NDEV);
      end
      if (w_eoi_bad) r_err <= 1'b1;
      else if (w_sel_stat && we && !dbus[17]) r_err <= 1'b0;
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: scoreboard bench driving a fixed-priority and a rotating-priority intr_ctrl from one CPU bus
module tb_intr_ctrl;
  localparam logic [31:0] IMASK = 32'hF0000800, IID = 32'hF0000804, IEOI = 32'hF0000808, ISTAT = 32'hF000080C;
  localparam logic [31:0] HIZ = 32'hFFFFFFFF;
  typedef struct {
    int cyc;
    int sel;
    int dut;
    logic [31:0] exp;
    string tag;
  } chk_t;
  logic clk = 0, init_n, we, cpu_oe;
  logic [31:0] abus, cpu_d;
  logic [3:0] dev_intr;
  logic irq0, irq1;
  logic [7:0] cid0, cid1;
  wire [31:0] dbus0, dbus1;
  chk_t sb[$];
  int cyc_n = 0, n_chk = 0, n_fail = 0;
  assign dbus0 = cpu_oe ? cpu_d : 'z;
  assign dbus1 = cpu_oe ? cpu_d : 'z;
  pullup pu0 (dbus0);
  pullup pu1 (dbus1);
  intr_ctrl #(.ROTATE(0)) u_fix (.clk(clk), .init_n(init_n), .abus(abus), .dbus(dbus0), .we(we),
                                 .dev_intr(dev_intr), .irq(irq0), .cur_id(cid0));
  intr_ctrl #(.ROTATE(1)) u_rot (.clk(clk), .init_n(init_n), .abus(abus), .dbus(dbus1), .we(we),
                                 .dev_intr(dev_intr), .irq(irq1), .cur_id(cid1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      c = sb.pop_front();
      act = c.sel == 0 ? (c.dut != 0 ? dbus1 : dbus0) :
            c.sel == 1 ? {31'b0, c.dut != 0 ? irq1 : irq0} : {24'b0, c.dut != 0 ? cid1 : cid0};
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.tag, act, c.exp);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(int sel, int dut, logic [31:0] exp, string tag);
    sb.push_back('{cyc_n, sel, dut, exp, tag});
  endtask
  task automatic wr(logic [31:0] a, logic [31:0] d);
    abus = a;
    cpu_d = d;
    we = 1;
    cpu_oe = 1;
    tick();
    we = 0;
    cpu_oe = 0;
    abus = 0;
  endtask
  task automatic rd(logic [31:0] a, int dut, logic [31:0] exp, string tag);
    abus = a;
    push(0, dut, exp, tag);
    tick();
    abus = 0;
  endtask
  task automatic rd2(logic [31:0] a, logic [31:0] e0, logic [31:0] e1, string t0, string t1);
    abus = a;
    push(0, 0, e0, t0);
    push(0, 1, e1, t1);
    tick();
    abus = 0;
  endtask
  initial begin
    init_n = 0;
    we = 0;
    cpu_oe = 0;
    abus = 0;
    cpu_d = 0;
    dev_intr = 0;
    repeat (3) tick();
    push(1, 0, 0, "rst_irq");
    push(2, 0, 0, "rst_cid");
    push(0, 0, HIZ, "rst_dbus_z");
    tick();
    init_n = 1;
    rd(IMASK, 0, 0, "mask_init");
    wr(IMASK, 32'h4);
    dev_intr = 4'b0100;
    tick();
    push(1, 0, 0, "irq_edge_n");
    tick();
    push(1, 0, 1, "irq_edge_n1");
    wr(IID, 32'h0);
    push(1, 0, 1, "iid_write_ignored");
    rd2(IID, 32'h80000002, 32'h80000002, "iid_basic_fix", "iid_basic_rot");
    push(1, 0, 0, "irq_after_ack");
    push(2, 0, 2, "cid_after_ack");
    rd(IEOI, 0, HIZ, "ieoi_read_z");
    wr(IEOI, 32'h2);
    push(1, 0, 0, "irq_after_eoi");
    push(2, 0, 0, "cid_after_eoi");
    tick();
    push(1, 0, 1, "irq_reentry");
    wr(IMASK, 32'h0);
    tick();
    tick();
    push(1, 0, 0, "irq_masked");
    rd(IID, 0, 0, "iid_idle");
    rd(ISTAT, 0, 0, "stat_idle");
    wr(IMASK, 32'h4);
    tick();
    tick();
    push(1, 0, 1, "irq_remask");
    rd(IID, 0, 32'h80000002, "iid_bad_eoi");
    wr(IEOI, 32'h3);
    rd(ISTAT, 0, 32'h00030004, "stat_err_set");
    wr(ISTAT, 32'h0);
    rd(ISTAT, 0, 32'h00010004, "stat_err_clr");
    wr(IEOI, 32'h2);
    rd(ISTAT, 0, 32'h00000004, "stat_eoi_done");
    #1 init_n = 0;
    dev_intr = 4'b1010;
    tick();
    init_n = 1;
    wr(IMASK, 32'hF);
    tick();
    tick();
    rd2(IID, 32'h80000001, 32'h80000001, "prio_fix_1", "prio_rot_1");
    wr(IEOI, 32'h1);
    tick();
    rd2(IID, 32'h80000001, 32'h80000003, "prio_fix_again", "prio_rot_3");
    wr(IEOI, 32'h3);
    tick();
    rd2(IID, 32'h00000000, 32'h80000001, "fix_iid_in_service", "prio_rot_wrap");
    rd(ISTAT, 0, 32'h0003000A, "fix_stat_err");
    push(2, 1, 1, "rot_cid_service");
    tick();
    #2 init_n = 0;
    push(1, 1, 0, "rst_async_irq");
    push(2, 1, 0, "rst_async_cid");
    push(0, 1, HIZ, "rst_async_dbus_z");
    tick();
    init_n = 1;
    rd(IMASK, 1, 0, "mask_after_rst");
    push(1, 0, 0, "irq_after_rst");
    tick();
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
